// File: rtl/tetris_move_ctrl_if.sv
// Request/result bundle between the key/gravity front end, the move sequencer
// and the field renderer.
interface tetris_move_ctrl_if;
    logic [7:0]   key_code;
    logic         key_valid;
    logic         gravity_tick;
    logic [399:0] field;
    logic         busy;
    logic         lock_pulse;
    logic [15:0]  lines_cleared;
    logic         game_over;

    modport master (
        output key_code, key_valid, gravity_tick,
        input  field, busy, lock_pulse, lines_cleared, game_over
    );

    modport slave (
        input  key_code, key_valid, gravity_tick,
        output field, busy, lock_pulse, lines_cleared, game_over
    );
endinterface

// File: rtl/tetris_move_ctrl.sv
// Playfield sequencer: owns the falling piece and the locked stack, validates
// every move against walls and stack, locks, clears full rows and respawns.
module tetris_move_ctrl #(
    parameter int           COLS      = 20,
    parameter int           ROWS      = 20,
    parameter logic [399:0] SPAWN     = 400'h700,
    parameter logic [7:0]   KEY_LEFT  = 8'h23,
    parameter logic [7:0]   KEY_RIGHT = 8'h34,
    parameter logic [7:0]   KEY_DOWN  = 8'h2b,
    parameter logic [7:0]   KEY_DROP  = 8'h2d
) (
    input  logic              clock,
    input  logic              resetn,
    tetris_move_ctrl_if.slave bus
);

    localparam int N     = COLS * ROWS;
    localparam int ROW_W = $clog2(ROWS);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_DROP, S_LOCK, S_CLEAR, S_SPAWN, S_OVER
    } state_t;

    typedef enum logic [1:0] {MV_LEFT, MV_RIGHT, MV_DOWN, MV_DROP} move_t;

    function automatic logic [N-1:0] col_mask(input int col);
        logic [N-1:0] m;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            m[r*COLS+col] = 1'b1;
        end
        return m;
    endfunction

    // Column masks stop shifts from wrapping a cell into the neighbouring row.
    localparam logic [N-1:0] LEFT_COL   = col_mask(0);
    localparam logic [N-1:0] RIGHT_COL  = col_mask(COLS - 1);
    localparam logic [N-1:0] BOTTOM_ROW = {{COLS{1'b1}}, {(N-COLS){1'b0}}};

    state_t           state_r, state_n;
    move_t            move_r, move_n;
    logic [N-1:0]     piece_r, piece_n;
    logic [N-1:0]     locked_r, locked_n;
    logic [N-1:0]     cand_r, cand_n;
    logic             pend_r, pend_n;
    logic [ROW_W-1:0] row_r, row_n;
    logic [15:0]      lines_r, lines_n;
    logic             over_r, over_n;
    logic [N-1:0]     field_r;
    logic             busy_r;
    logic             lock_pulse_r;

    logic [N-1:0]     left_c_s, right_c_s, down_c_s;
    logic             left_blk_s, right_blk_s, down_blk_s;
    logic             key_left_s, key_right_s, key_down_s, key_drop_s, key_hit_s;
    logic             row_full_s;
    logic [N-1:0]     keep_mask_s, shifted_s;

    assign left_c_s    = piece_r >> 1;
    assign right_c_s   = piece_r << 1;
    assign down_c_s    = piece_r << COLS;
    assign left_blk_s  = (|(piece_r & LEFT_COL))   || (|(left_c_s & locked_r));
    assign right_blk_s = (|(piece_r & RIGHT_COL))  || (|(right_c_s & locked_r));
    assign down_blk_s  = (|(piece_r & BOTTOM_ROW)) || (|(down_c_s & locked_r));

    assign key_left_s  = bus.key_valid && (bus.key_code == KEY_LEFT);
    assign key_right_s = bus.key_valid && (bus.key_code == KEY_RIGHT);
    assign key_down_s  = bus.key_valid && (bus.key_code == KEY_DOWN);
    assign key_drop_s  = bus.key_valid && (bus.key_code == KEY_DROP);
    assign key_hit_s   = key_left_s || key_right_s || key_down_s || key_drop_s;

    // Rows above the scanned row move down one; rows below it are untouched.
    assign row_full_s  = &locked_r[int'(row_r)*COLS +: COLS];
    assign keep_mask_s = {N{1'b1}} << ((int'(row_r) + 1) * COLS);
    assign shifted_s   = (locked_r & keep_mask_s) | ((locked_r << COLS) & ~keep_mask_s);

    // Next-state and datapath update for the move/lock/clear sequencer.
    always_comb begin
        state_n  = state_r;
        move_n   = move_r;
        piece_n  = piece_r;
        locked_n = locked_r;
        cand_n   = cand_r;
        pend_n   = pend_r | bus.gravity_tick;
        row_n    = row_r;
        lines_n  = lines_r;
        over_n   = over_r;
        case (state_r)
            S_IDLE: begin
                if (key_hit_s) begin
                    state_n = S_CHECK;
                    if (key_left_s) begin
                        move_n = MV_LEFT;
                        cand_n = left_c_s;
                    end else if (key_right_s) begin
                        move_n = MV_RIGHT;
                        cand_n = right_c_s;
                    end else if (key_down_s) begin
                        move_n = MV_DOWN;
                        cand_n = down_c_s;
                    end else begin
                        move_n = MV_DROP;
                        cand_n = down_c_s;
                    end
                end else if (bus.gravity_tick || pend_r) begin
                    state_n = S_CHECK;
                    move_n  = MV_DOWN;
                    cand_n  = down_c_s;
                    pend_n  = 1'b0;
                end else begin
                    state_n = S_IDLE;
                end
            end
            S_CHECK: begin
                case (move_r)
                    MV_LEFT: begin
                        state_n = S_IDLE;
                        piece_n = left_blk_s ? piece_r : cand_r;
                    end
                    MV_RIGHT: begin
                        state_n = S_IDLE;
                        piece_n = right_blk_s ? piece_r : cand_r;
                    end
                    MV_DOWN: begin
                        if (down_blk_s) begin
                            state_n = S_LOCK;
                        end else begin
                            state_n = S_IDLE;
                            piece_n = cand_r;
                        end
                    end
                    MV_DROP: state_n = S_DROP;
                    default: state_n = S_IDLE;
                endcase
            end
            S_DROP: begin
                if (down_blk_s) begin
                    state_n = S_LOCK;
                end else begin
                    piece_n = down_c_s;
                end
            end
            S_LOCK: begin
                locked_n = locked_r | piece_r;
                piece_n  = '0;
                row_n    = ROW_W'(ROWS - 1);
                state_n  = S_CLEAR;
            end
            S_CLEAR: begin
                if (row_full_s) begin
                    locked_n = shifted_s;
                    lines_n  = (lines_r == 16'hFFFF) ? lines_r : lines_r + 16'd1;
                end else if (row_r == '0) begin
                    state_n = S_SPAWN;
                end else begin
                    row_n = row_r - ROW_W'(1);
                end
            end
            S_SPAWN: begin
                if (|(SPAWN & locked_r)) begin
                    piece_n = '0;
                    over_n  = 1'b1;
                    state_n = S_OVER;
                end else begin
                    piece_n = SPAWN;
                    state_n = S_IDLE;
                end
            end
            S_OVER:  state_n = S_OVER;
            default: state_n = S_IDLE;
        endcase
    end

    // State, datapath and registered outputs; field shows last cycle's piece|stack.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r      <= S_IDLE;
            move_r       <= MV_DOWN;
            piece_r      <= SPAWN;
            locked_r     <= '0;
            cand_r       <= '0;
            pend_r       <= 1'b0;
            row_r        <= '0;
            lines_r      <= 16'd0;
            over_r       <= 1'b0;
            field_r      <= SPAWN;
            busy_r       <= 1'b0;
            lock_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_n;
            move_r       <= move_n;
            piece_r      <= piece_n;
            locked_r     <= locked_n;
            cand_r       <= cand_n;
            pend_r       <= pend_n;
            row_r        <= row_n;
            lines_r      <= lines_n;
            over_r       <= over_n;
            field_r      <= piece_r | locked_r;
            busy_r       <= (state_n != S_IDLE);
            lock_pulse_r <= (state_n == S_LOCK);
        end
    end

    assign bus.field         = field_r;
    assign bus.busy          = busy_r;
    assign bus.lock_pulse    = lock_pulse_r;
    assign bus.lines_cleared = lines_r;
    assign bus.game_over     = over_r;

endmodule
